// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: queues producer writes and issues one
// tx_en strobe per byte, waiting for a tx_done rising edge before the next.
module uart_tx_fifo #(
    parameter int unsigned data_width     = 8,
    parameter int unsigned depth_log2     = 4,
    parameter bit          run_active_low = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [depth_log2:0]   count,
    output logic                  overflow,
    output logic                  busy,
    output logic [data_width-1:0] data_tx,
    output logic                  tx_en,
    input  logic                  tx_done
);

    localparam int unsigned DEPTH     = 2 ** depth_log2;
    localparam int unsigned CW        = depth_log2 + 1;
    localparam logic        TX_ACTIVE = run_active_low ? 1'b0 : 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [data_width-1:0] r_mem [DEPTH];
    logic [depth_log2-1:0] r_wr_ptr;
    logic [depth_log2-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;
    logic                  r_busy;
    logic                  r_tx_en;
    logic [data_width-1:0] r_data_tx;
    logic                  r_done_q;

    logic                  w_done_rise;
    logic                  w_wr_acc;
    logic                  w_pop;
    logic                  w_tx_en_nxt;
    logic                  w_busy_nxt;
    logic [CW-1:0]         w_count_nxt;

    assign w_done_rise = tx_done & ~r_done_q;
    // Write admission uses the registered full flag; a same-cycle pop never makes room.
    assign w_wr_acc    = wr_en & ~r_full & ~flush;

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : next_state
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!r_empty && !flush) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_done_rise) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin : fsm_outputs
        w_pop       = 1'b0;
        w_tx_en_nxt = ~TX_ACTIVE;
        w_busy_nxt  = 1'b0;
        if (r_state == S_IDLE && !r_empty && !flush) w_pop = 1'b1;
        if (w_state_nxt == S_START) w_tx_en_nxt = TX_ACTIVE;
        if (w_state_nxt != S_IDLE) w_busy_nxt = 1'b1;
    end

    always_comb begin : count_next
        w_count_nxt = r_count;
        if (w_wr_acc && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr_acc && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin : mem_write
        if (w_wr_acc && !rst) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Flush clears the queue and overflow but leaves any byte in flight alone.
    always_ff @(posedge clk) begin : fifo_ctrl
        if (rst || flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            if (wr_en && r_full) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin : out_regs
        if (rst) begin
            r_tx_en   <= ~TX_ACTIVE;
            r_busy    <= 1'b0;
            r_data_tx <= '0;
            r_done_q  <= 1'b0;
        end else begin
            r_done_q <= tx_done;
            r_tx_en  <= w_tx_en_nxt;
            r_busy   <= w_busy_nxt;
            if (w_pop) r_data_tx <= r_mem[r_rd_ptr];
        end
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign busy     = r_busy;
    assign data_tx  = r_data_tx;
    assign tx_en    = r_tx_en;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and scheduler that sits directly upstream of the UART top level and feeds its transmit side.
- Producers push bytes at their own pace. The block drains them one at a time into the transmitter through the data_tx / tx_en / tx_done interface, and waits for each byte to complete before starting the next.
- Producers never have to track transmitter busy state.

Parameters:
- data_width, 8: byte width; must match the UART data_width.
- depth_log2, 4: FIFO depth is 2**depth_log2 entries (default 16).
- run_active_low, 1: 1 means tx_en idles high and asserts low; 0 means tx_en idles low and asserts high.

Ports:
- clk  in  1  single system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_data  in  data_width  byte to enqueue.
- wr_en  in  1  enqueue strobe; sampled every cycle.
- flush  in  1  clears queued (not yet started) bytes and the overflow flag.
- full  out  1  FIFO holds 2**depth_log2 entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  depth_log2+1  number of queued entries, excluding the byte in flight.
- overflow  out  1  sticky: a write was dropped.
- busy  out  1  high when the FSM is not IDLE.
- data_tx  out  data_width  byte presented to the transmitter.
- tx_en  out  1  transmitter start strobe, polarity set by run_active_low.
- tx_done  in  1  transmitter completion indication from the UART.

Behaviour:
- Reset (rst high at an edge):
  - FIFO pointers and count go to 0; full=0, empty=1, overflow=0, busy=0, data_tx=0.
  - tx_en goes to its inactive level; FSM goes to IDLE; the tx_done edge register is cleared.
  - Reset mid-transfer abandons the byte in flight. No further tx_en assertion occurs for it.
- FIFO:
  - Circular buffer with wrapping read/write pointers; count is a separate registered counter.
  - Write accepted iff wr_en=1 and full=0, judged on the registered full value at that edge. A pop in the same cycle does not make room.
  - Write while full: the data is dropped, overflow is set to 1, FIFO is unchanged.
  - Simultaneous accepted write and pop: count is unchanged and both pointers advance.
  - full and empty are derived from count (count == 2**depth_log2 and count == 0).
- flush:
  - At the edge it is sampled: pointers and count go to 0 and overflow goes to 0.
  - Priority: a wr_en in the same cycle is ignored.
  - Does not disturb the FSM; a byte already in START or WAIT completes normally.
- FSM states:
  - IDLE: if empty=0 (and no flush this cycle), pop the head into data_tx and go to START. Otherwise stay.
  - START: drive tx_en active for exactly one cycle, go to WAIT. data_tx stays stable.
  - WAIT: tx_en inactive; data_tx held. On a rising edge of tx_done (current 1, previous 0), go to IDLE. Otherwise stay, with no timeout.
- data_tx changes only on the pop in IDLE, so it is stable from the START cycle until the next pop.
- tx_done is edge-detected. A tx_done level still high from the previous byte, or high before START, does not complete the current byte. The edge register samples every cycle in all states.
- Latency into an empty FIFO, idle FSM, write accepted at edge k:
  - count=1 after k.
  - Pop and data_tx valid after edge k+1.
  - tx_en active during the cycle between edges k+1 and k+2.
- Byte-to-byte: the rising tx_done edge is detected at edge d. IDLE pops at d+1, and tx_en is active for the next byte in the cycle after d+1.
- busy=1 in START and WAIT, 0 in IDLE.

Test Plan:
1. Single byte:
   - Stimulus: after reset, write 0xA5 once. Model tx_done rising 20 cycles after the tx_en pulse.
   - Response: data_tx=0xA5 from edge k+1, exactly one active tx_en cycle, busy drops 1 cycle after the tx_done edge, count returns to 0.
2. Ordering / back-to-back:
   - Stimulus: write 0x01, 0x02, 0x03 in consecutive cycles.
   - Response: three tx_en pulses, data_tx sequence 0x01, 0x02, 0x03. Each pulse occurs only after the previous byte's tx_done edge.
3. Full / overflow:
   - Stimulus: with depth 16 and tx_done held low, write 18 bytes 0x00..0x11.
   - Response:
     - 1 byte is in flight, 16 are queued, full=1, count=16.
     - Byte 0x11 is dropped and overflow=1 and stays 1.
     - After releasing tx_done, bytes 0x00..0x10 are transmitted in order.
4. Stale done level:
   - Stimulus: hold tx_done=1 continuously, then write 0x55.
   - Response: the FSM stays in WAIT after START. It completes only after tx_done goes 0 then 1.
5. Flush mid-transfer:
   - Stimulus: queue 0x10..0x14, then assert flush while 0x10 is in WAIT, with wr_en=1 in the same cycle.
   - Response: count=0, overflow=0, the write is ignored, 0x10 completes, no further tx_en pulses.
6. Reset mid-transfer and polarity:
   - Stimulus: assert rst during WAIT; repeat scenario 1 with run_active_low=0.
   - Response: all outputs return to their reset values and tx_en goes to its inactive level (high for run_active_low=1, low for run_active_low=0). With run_active_low=0, tx_en pulses high for exactly one cycle.
